l2_request_issue: RTL and testbench
===================================

// Module: l2_request_issue
// PURPOSE
//  Issue stage directly downstream of the L2 round-robin arbiter.
//  - Presents per-port request valids to the arbiter and pops the granted port's request.
//  - Registers that request onto the single L2 request channel, tagged with the port id.
//  - For writes, forwards the granted port's write-data burst, asserting wlast on the final beat.
//  - Only one request is in flight at a time; arbitration is frozen until it completes.
// PARAMETERS
//  NUM_PORTS  4   number of requesting ports; IDX_W = max(1,$clog2(NUM_PORTS))
//  ADDR_W     30  request word address width
//  LEN_W      5   burst length field width; value = beats-1
//  DATA_W     32  write data width
// PORTS
//  clk               in   1                clock
//  rst               in   1                reset, synchronous, active-high
//  req_valid         in   NUM_PORTS        per-port request pending
//  req_addr          in   NUM_PORTS*ADDR_W port p at [p*ADDR_W +: ADDR_W]
//  req_rnw           in   NUM_PORTS        1=read, 0=write
//  req_len           in   NUM_PORTS*LEN_W  beats-1, port p at [p*LEN_W +: LEN_W]
//  req_ready         out  NUM_PORTS        one-hot pop of granted port's request
//  wdata_valid       in   NUM_PORTS        per-port write data available
//  wdata             in   NUM_PORTS*DATA_W port p at [p*DATA_W +: DATA_W]
//  wdata_ready       out  NUM_PORTS        one-hot pop of granted port's write data
//  arb_requests      out  NUM_PORTS        request vector to arbiter
//  arb_strobe        out  1                grant accepted; arbiter advances priority
//  arb_grantee_valid in   1                arbiter has a grantee
//  arb_grantee_i     in   IDX_W            granted port index
//  out_valid         out  1                L2 request valid
//  out_addr          out  ADDR_W           registered request address
//  out_rnw           out  1                registered read/not-write
//  out_len           out  LEN_W            registered beats-1
//  out_id            out  IDX_W            originating port index
//  out_ready         in   1                L2 accepts request
//  out_wvalid        out  1                write beat valid
//  out_wdata         out  DATA_W           write beat data
//  out_wlast         out  1                final beat of burst
//  out_wready        in   1                L2 accepts write beat
//  busy              out  1                state != IDLE
// BEHAVIOUR
//  States
//   - IDLE:
//     - arb_requests = req_valid; arb_requests = 0 in all other states and while rst.
//     - If arb_grantee_valid, the same cycle drives: arb_strobe=1; req_ready[arb_grantee_i]=1.
//     - Next edge registers addr/rnw/len of the granted port; out_id<=arb_grantee_i; out_valid<=1; ->HOLD.
//   - HOLD:
//     - out_valid=1; out_* fields stable until out_ready.
//     - On out_ready, a read -> IDLE with out_valid<=0.
//     - On out_ready, a write -> WDATA with out_valid<=0 and beat counter<=out_len.
//   - WDATA:
//     - out_wvalid=wdata_valid[out_id]; out_wdata=wdata[out_id].
//     - wdata_ready[out_id]=out_wready; all other wdata_ready bits 0.
//     - out_wlast=(counter==0)&out_wvalid.
//     - On a beat (out_wvalid&out_wready): counter==0 -> IDLE, else counter--.
//  Strobe and pops
//   - arb_strobe, req_ready and wdata_ready are combinational and are 0 outside the cases above.
//   - Exactly one arb_strobe per issued request.
//  Latency and throughput
//   - Grant to out_valid: 1 cycle.
//   - Back-to-back reads: one request per 2 cycles minimum.
//   - Write: 1 request handshake + (len+1) beat handshakes.
//  Boundaries
//   - len=0 gives a single beat with wlast.
//   - len=2^LEN_W-1 gives 2^LEN_W beats with no counter wrap.
//   - wdata_valid gaps and out_wready stalls are tolerated; only handshaked beats count; wlast is held until accepted.
//   - Requests arriving or dropping on other ports while busy are ignored.
//   - Upstream holds req fields stable while req_valid & !req_ready.
//  Reset (rst)
//   - state=IDLE; out_valid=0; out_addr/out_rnw/out_len/out_id=0; counter=0.
//   - All combinational outputs are 0 during rst.
//   - rst mid-burst abandons the burst with no wlast and no further pops.
// TESTING
//  1. rst held 3 cycles, all req_valid=1 -> arb_requests=0, arb_strobe=0, out_valid=0; arb_strobe=1 first cycle after release.
//  2. Port 2 read, addr 0x100, len 0, out_ready=1 -> strobe + req_ready=4'b0100 at cycle 0; cycle 1 out_valid, out_id=2, out_addr=0x100; busy=0 at cycle 2.
//  3. Port 1 write, len 3, out_ready low 4 cycles -> out_* stable; then 4 beats, wdata_ready only bit 1, wlast on 4th beat only.
//  4. Write burst with wdata_valid toggling and out_wready 50% random -> exactly len+1 handshaked beats, data order preserved, wlast held until accepted.
//  5. All 4 ports requesting reads, out_ready=1, driven by the L2 round-robin arbiter -> out_id sequence 3,2,1,0,3; strobe count = issued count.
//  6. rst asserted after 2 of 4 write beats -> next cycle IDLE, out_wvalid=0, no wlast; subsequent read issues normally.

Source files
------------

// File: rtl/l2_request_issue_if.sv
// Handshake bundle between the L2 request issue stage, its requesting ports,
// the round-robin arbiter and the single L2 request/write-data channel.
interface l2_request_issue_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 30,
    parameter int LEN_W     = 5,
    parameter int DATA_W    = 32
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0]        req_rnw;
    logic [NUM_PORTS*LEN_W-1:0]  req_len;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        wdata_valid;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        wdata_ready;
    logic [NUM_PORTS-1:0]        arb_requests;
    logic                        arb_strobe;
    logic                        arb_grantee_valid;
    logic [IDX_W-1:0]            arb_grantee_i;
    logic                        out_valid;
    logic [ADDR_W-1:0]           out_addr;
    logic                        out_rnw;
    logic [LEN_W-1:0]            out_len;
    logic [IDX_W-1:0]            out_id;
    logic                        out_ready;
    logic                        out_wvalid;
    logic [DATA_W-1:0]           out_wdata;
    logic                        out_wlast;
    logic                        out_wready;
    logic                        busy;

    // master: the issue stage itself; slave: ports, arbiter and L2 around it
    modport master (
        input  req_valid, req_addr, req_rnw, req_len, wdata_valid, wdata,
        input  arb_grantee_valid, arb_grantee_i, out_ready, out_wready,
        output req_ready, wdata_ready, arb_requests, arb_strobe,
        output out_valid, out_addr, out_rnw, out_len, out_id,
        output out_wvalid, out_wdata, out_wlast, busy
    );

    modport slave (
        output req_valid, req_addr, req_rnw, req_len, wdata_valid, wdata,
        output arb_grantee_valid, arb_grantee_i, out_ready, out_wready,
        input  req_ready, wdata_ready, arb_requests, arb_strobe,
        input  out_valid, out_addr, out_rnw, out_len, out_id,
        input  out_wvalid, out_wdata, out_wlast, busy
    );
endinterface

// File: rtl/l2_request_issue.sv
// Issue stage behind the L2 round-robin arbiter: pops the granted request, holds
// it on the L2 request channel, then forwards the write burst for writes.
//
// state | meaning
// IDLE  | arbiter sees req_valid; a grantee is popped and registered
// HOLD  | out_valid high, request fields frozen until out_ready
// WDATA | forwarding write beats from port out_id, beat_cnt beats left minus one
module l2_request_issue #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 30,
    parameter int LEN_W     = 5,
    parameter int DATA_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    l2_request_issue_if.master bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        WDATA = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               out_valid_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rnw_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   id_q;
    logic [LEN_W-1:0]   beat_cnt;

    logic                 grant, req_hs, beat;
    logic [NUM_PORTS-1:0] arb_requests_c, req_ready_c, wdata_ready_c;
    logic                 arb_strobe_c, out_wvalid_c, out_wlast_c;
    logic [DATA_W-1:0]    out_wdata_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            len_q       <= '0;
            id_q        <= '0;
            beat_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                addr_q      <= bus.req_addr[bus.arb_grantee_i*ADDR_W +: ADDR_W];
                rnw_q       <= bus.req_rnw[bus.arb_grantee_i];
                len_q       <= bus.req_len[bus.arb_grantee_i*LEN_W +: LEN_W];
                id_q        <= bus.arb_grantee_i;
                out_valid_q <= 1'b1;
            end
            if (req_hs) begin
                out_valid_q <= 1'b0;
                if (!rnw_q)
                    beat_cnt <= len_q;
            end
            // counter stops at zero; the final beat leaves WDATA instead of wrapping
            if (beat && beat_cnt != '0)
                beat_cnt <= beat_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        req_hs         = 1'b0;
        beat           = 1'b0;
        arb_requests_c = '0;
        arb_strobe_c   = 1'b0;
        req_ready_c    = '0;
        wdata_ready_c  = '0;
        out_wvalid_c   = 1'b0;
        out_wdata_c    = '0;
        out_wlast_c    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    arb_requests_c = bus.req_valid;
                    if (bus.arb_grantee_valid) begin
                        grant                          = 1'b1;
                        arb_strobe_c                   = 1'b1;
                        req_ready_c[bus.arb_grantee_i] = 1'b1;
                        state_nxt                      = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        req_hs    = 1'b1;
                        state_nxt = rnw_q ? IDLE : WDATA;
                    end
                end
                WDATA: begin
                    out_wvalid_c        = bus.wdata_valid[id_q];
                    out_wdata_c         = bus.wdata[id_q*DATA_W +: DATA_W];
                    wdata_ready_c[id_q] = bus.out_wready;
                    out_wlast_c         = (beat_cnt == '0) && out_wvalid_c;
                    beat                = out_wvalid_c && bus.out_wready;
                    if (beat && beat_cnt == '0)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.arb_requests = arb_requests_c;
    assign bus.arb_strobe   = arb_strobe_c;
    assign bus.req_ready    = req_ready_c;
    assign bus.wdata_ready  = wdata_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_addr     = addr_q;
    assign bus.out_rnw      = rnw_q;
    assign bus.out_len      = len_q;
    assign bus.out_id       = id_q;
    assign bus.out_wvalid   = out_wvalid_c;
    assign bus.out_wdata    = out_wdata_c;
    assign bus.out_wlast    = out_wlast_c;
    assign bus.busy         = !rst && (state != IDLE);
endmodule

// File: tb/tb_l2_request_issue.sv
// Bench for l2_request_issue: directed steps plus random traffic, checked against a
// transaction-level model of ports, the in-flight request and the write burst.
module tb_l2_request_issue;
    localparam int N  = 4;
    localparam int AW = 30;
    localparam int LW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_request_issue_if #(.NUM_PORTS(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) bus ();
    l2_request_issue #(.NUM_PORTS(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // round-robin arbiter: search downward from rr_ptr, next search starts below the grantee
    int         rr_ptr = N - 1;
    logic       arb_v;
    logic [1:0] arb_i;
    always_comb begin
        arb_v = 1'b0;
        arb_i = '0;
        for (int k = 0; k < N; k++)
            if (!arb_v && bus.arb_requests[(rr_ptr - k + N) % N]) begin
                arb_v = 1'b1;
                arb_i = 2'((rr_ptr - k + N) % N);
            end
    end
    assign bus.arb_grantee_valid = arb_v;
    assign bus.arb_grantee_i     = arb_i;

    // port-side stimulus state
    logic [N-1:0]  pend = '0;
    logic [AW-1:0] p_addr [N];
    logic          p_rnw  [N];
    logic [LW-1:0] p_len  [N];
    logic [DW-1:0] wq     [N][$];
    logic          wd_en  [N];
    logic          out_ready_d = 1'b1, wready_d = 1'b1, rand_rdy = 1'b0;

    // transaction model
    bit            issued = 0, writing = 0;
    int            iss_id, w_rem, w_id;
    logic [AW-1:0] iss_addr;
    logic          iss_rnw;
    logic [LW-1:0] iss_len;

    int errors = 0, checks = 0;
    int strobes = 0, issues = 0, beats = 0, wlasts = 0;
    int id_log[$];

    logic          s_rst, s_strobe, s_out_valid, s_busy, s_wvalid, s_wlast;
    logic [N-1:0]  s_req_ready;
    logic [1:0]    s_out_id;
    logic [AW-1:0] s_out_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (rand_rdy) begin
            out_ready_d = 1'($urandom_range(0, 1));
            wready_d    = 1'($urandom_range(0, 1));
            for (int p = 0; p < N; p++) wd_en[p] = 1'($urandom_range(0, 1));
        end
        bus.req_valid  = pend;
        bus.out_ready  = out_ready_d;
        bus.out_wready = wready_d;
        for (int p = 0; p < N; p++) begin
            bus.req_addr[p*AW +: AW] = p_addr[p];
            bus.req_rnw[p]           = p_rnw[p];
            bus.req_len[p*LW +: LW]  = p_len[p];
            bus.wdata_valid[p]       = (wq[p].size() != 0) && wd_en[p];
            bus.wdata[p*DW +: DW]    = (wq[p].size() != 0) ? wq[p][0] : '0;
        end
    endtask

    task automatic new_req(input int p, input logic rnw, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        pend[p]   = 1'b1;
        p_rnw[p]  = rnw;
        p_addr[p] = addr;
        p_len[p]  = len;
        if (!rnw)
            for (int b = 0; b <= int'(len); b++) wq[p].push_back($urandom);
        drive();
    endtask

    task automatic tick();
        logic         ev_grant, ev_hs, ev_beat, exp_wv, exp_strobe;
        logic [N-1:0] exp_rr, exp_wr;
        int           g;
        @(negedge clk);
        s_rst = rst;  s_strobe = bus.arb_strobe;  s_req_ready = bus.req_ready;
        s_out_valid = bus.out_valid;  s_out_id = bus.out_id;  s_out_addr = bus.out_addr;
        s_busy = bus.busy;  s_wvalid = bus.out_wvalid;  s_wlast = bus.out_wlast;
        ev_grant = 0; ev_hs = 0; ev_beat = 0; g = int'(arb_i);
        if (rst) begin
            chk("rst_arb_requests", bus.arb_requests, '0);
            chk("rst_strobe", bus.arb_strobe, 0);
            chk("rst_ready", {bus.req_ready, bus.wdata_ready}, '0);
            chk("rst_wvalid_wlast", {bus.out_wvalid, bus.out_wlast}, '0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy", bus.busy, 0);
        end else begin
            exp_strobe = !issued && !writing && (pend != '0);
            chk("busy", bus.busy, issued || writing);
            chk("out_valid", bus.out_valid, issued);
            chk("arb_requests", bus.arb_requests, (issued || writing) ? '0 : pend);
            chk("arb_strobe", bus.arb_strobe, exp_strobe);
            exp_rr = '0;
            if (exp_strobe) exp_rr[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rr);
            if (issued)
                chk("out_fields", {bus.out_id, bus.out_rnw, bus.out_len, bus.out_addr},
                    {2'(iss_id), iss_rnw, iss_len, iss_addr});
            exp_wv = writing && wd_en[w_id] && (wq[w_id].size() != 0);
            exp_wr = '0;
            if (writing) exp_wr[w_id] = wready_d;
            chk("wdata_ready", bus.wdata_ready, exp_wr);
            chk("out_wvalid", bus.out_wvalid, exp_wv);
            chk("out_wlast", bus.out_wlast, exp_wv && (w_rem == 1));
            if (exp_wv) chk("out_wdata", bus.out_wdata, wq[w_id][0]);
            ev_grant = exp_strobe;
            ev_hs    = issued && out_ready_d;
            ev_beat  = exp_wv && wready_d;
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            if (writing) wq[w_id].delete();
            if (issued && !iss_rnw) wq[iss_id].delete();
            issued = 0; writing = 0; rr_ptr = N - 1;
        end else begin
            if (ev_beat) begin
                void'(wq[w_id].pop_front());
                beats++;
                if (w_rem == 1) begin wlasts++; writing = 0; end
                w_rem--;
            end
            if (ev_hs) begin
                issued = 0; issues++; id_log.push_back(iss_id);
                if (!iss_rnw) begin writing = 1; w_rem = int'(iss_len) + 1; w_id = iss_id; end
            end
            if (ev_grant) begin
                issued = 1; iss_id = g; iss_addr = p_addr[g]; iss_rnw = p_rnw[g]; iss_len = p_len[g];
                pend[g] = 1'b0; strobes++; rr_ptr = (g + N - 1) % N;
            end
        end
        drive();
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((issued || writing || pend != '0) && n < limit) begin tick(); n++; end
        chk("idle_timeout", n < limit, 1);
    endtask

    initial begin
        int b0, l0, i0;
        int exp_ids[5] = '{3, 2, 1, 0, 3};
        for (int p = 0; p < N; p++) begin
            wd_en[p] = 1'b1; p_addr[p] = '0; p_rnw[p] = 1'b1; p_len[p] = '0;
        end
        // reset with all ports requesting, then continuous reads for round-robin order
        for (int p = 0; p < N; p++) new_req(p, 1'b1, AW'(32'h40 * p), '0);
        repeat (3) tick();
        rst = 1'b0;
        drive();
        tick();
        chk("strobe_after_rst", s_strobe, 1);
        for (int n = 0; n < 40 && issues < 5; n++) begin
            tick();
            for (int p = 0; p < N; p++) if (!pend[p]) new_req(p, 1'b1, AW'($urandom), '0);
        end
        chk("rr_issue_count", issues >= 5, 1);
        for (int k = 0; k < 5 && k < id_log.size(); k++) chk("rr_order", id_log[k], exp_ids[k]);
        run_until_idle(100);
        chk("strobe_eq_issued", strobes, issues);

        // single read on port 2
        new_req(2, 1'b1, AW'(32'h100), '0);
        tick();
        chk("rd_strobe_c0", s_strobe, 1);
        chk("rd_req_ready_c0", s_req_ready, 4'b0100);
        tick();
        chk("rd_out_c1", {s_out_valid, s_out_id, s_out_addr}, {1'b1, 2'd2, AW'(32'h100)});
        tick();
        chk("rd_busy_c2", s_busy, 0);

        // port 1 write len 3 with request stalled 4 cycles
        out_ready_d = 1'b0;
        new_req(1, 1'b0, AW'(32'h2468), 5'd3);
        tick();
        repeat (4) begin tick(); chk("stall_out_valid", s_out_valid, 1); end
        out_ready_d = 1'b1;
        b0 = beats; l0 = wlasts;
        drive();
        run_until_idle(30);
        chk("wr3_beats", beats - b0, 4);
        chk("wr3_wlast", wlasts - l0, 1);

        // gappy bursts, including the maximum length
        rand_rdy = 1'b1;
        b0 = beats; l0 = wlasts;
        new_req(0, 1'b0, AW'(32'h77), 5'd7);
        run_until_idle(300);
        chk("wr7_beats", beats - b0, 8);
        chk("wr7_wlast", wlasts - l0, 1);
        b0 = beats;
        new_req(3, 1'b0, AW'(32'h1234), 5'd31);
        run_until_idle(600);
        chk("wr31_beats", beats - b0, 32);

        // reset after 2 of 4 beats abandons the burst
        rand_rdy = 1'b0; out_ready_d = 1'b1; wready_d = 1'b1;
        for (int p = 0; p < N; p++) wd_en[p] = 1'b1;
        b0 = beats; l0 = wlasts;
        new_req(3, 1'b0, AW'(32'h55), 5'd3);
        repeat (4) tick();
        chk("mid_beats", beats - b0, 2);
        rst = 1'b1; drive(); tick();
        rst = 1'b0; drive(); tick();
        chk("post_rst_idle", {s_busy, s_wvalid, s_wlast}, 3'b000);
        chk("post_rst_no_wlast", wlasts - l0, 0);
        i0 = issues;
        new_req(0, 1'b1, AW'(32'h99), 5'd2);
        run_until_idle(20);
        chk("post_rst_read", issues - i0, 1);

        // random mixed traffic
        rand_rdy = 1'b1;
        strobes = 0; issues = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p = $urandom_range(0, N - 1);
                if (!pend[p]) new_req(p, 1'($urandom_range(0, 1)), AW'($urandom), LW'($urandom_range(0, 7)));
            end
            tick();
        end
        run_until_idle(1000);
        chk("rand_strobe_eq_issued", strobes, issues);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
